if_id_skid_reg: RTL
===================

Name: if_id_skid_reg

Overview:
- Parametrised successor to the single PC register between IF and ID.
- Carries PC and instruction with a valid/ready handshake, a two-entry skid buffer and a synchronous flush.
- IF can issue every cycle while ID back-pressures without a combinational ready path from ID to IF.
- Sits between instruction-fetch and decode.

Parameters:
- PC_W, 32, width of PC field.
- INSTR_W, 32, width of instruction field.
- RESET_PC, 0, value driven on out_pc while reset is asserted and after reset until the first beat is loaded.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- in_valid  input  1  IF presents a beat.
- in_ready  output  1  register can accept a beat; driven straight from a flop.
- in_pc  input  PC_W  PC of the incoming beat.
- in_instr  input  INSTR_W  instruction of the incoming beat.
- flush  input  1  discard all held beats (branch taken or exception).
- out_valid  output  1  beat presented to ID.
- out_ready  input  1  ID accepts the beat.
- out_pc  output  PC_W  PC of the presented beat.
- out_instr  output  INSTR_W  instruction of the presented beat.

Behaviour:
- Storage:
  - main entry (m_valid, m_pc, m_instr) drives the outputs.
  - skid entry (s_valid, s_pc, s_instr) holds one overflow beat.
- Port mapping: out_valid = m_valid, out_pc = m_pc, out_instr = m_instr, in_ready = !s_valid.
- Reset (rst = 0, asynchronous):
  - m_valid = s_valid = 0.
  - m_pc = s_pc = RESET_PC; m_instr = s_instr = 0.
  - Outputs therefore read out_valid 0, in_ready 1, out_pc RESET_PC, out_instr 0.
- Events per cycle: acc = in_valid & in_ready; deq = m_valid & out_ready.
- Latency: a beat accepted at edge N appears on out_* after edge N, i.e. 1 cycle. Throughput is 1 beat/cycle while out_ready = 1.
- Transitions, evaluated at each rising edge when flush = 0:
  - m empty, acc: load main from in_*.
  - m full, deq, s empty, acc: load main from in_*.
  - m full, deq, s empty, no acc: m_valid <= 0; m_pc and m_instr hold their last values.
  - m full, !deq, acc: capture in_* into skid; s_valid <= 1 (in_ready drops next cycle).
  - m full, deq, s full: move skid to main; s_valid <= 0. acc is impossible here because in_ready = 0.
  - m full, !deq, s full: hold everything.
- Ordering: beats leave strictly in acceptance order and are never duplicated or dropped, flush excepted.
- Flush (synchronous, highest priority below reset):
  - At the edge with flush = 1: m_valid <= 0 and s_valid <= 0.
  - A beat offered in the same cycle is dropped even if in_valid & in_ready.
  - deq in that cycle still counts as consumed by ID.
  - in_ready = 1 the following cycle.
- Data fields of invalid entries hold their last value; they are never cleared except by reset.
- Reset asserted mid-transfer clears both entries immediately, without waiting for clk.
- Deassertion of rst is synchronised outside the block; the block assumes it is clean.
- The block never asserts out_valid without a prior acc.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined, two extra outputs are present:
  - stall_cnt (32 bits): +1 each cycle with in_valid & !in_ready.
  - drop_cnt (32 bits): +1 per valid beat discarded by flush, counting the main entry, the skid entry and a beat offered in the flush cycle, so +0..3 per flush.
  - Both saturate at 0xFFFFFFFF, reset to 0 and are not cleared by flush.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset:
  - Stimulus: rst = 0 while in_valid = 1, in_pc = 0x40.
  - Required: out_valid 0, in_ready 1, out_pc = RESET_PC (0), out_instr 0.
  - After rst = 1, first beat 0x40 appears one cycle after acceptance.
- Streaming:
  - Stimulus: out_ready = 1; beats pc 0x00, 0x04, 0x08, 0x0C on consecutive cycles.
  - Required: out_pc 0x00..0x0C on consecutive cycles, 1-cycle latency, in_ready stays 1.
- Back-pressure:
  - Stimulus: out_ready = 0 after beat 0x00 is in main; IF offers 0x04 then 0x08.
  - Required: 0x04 is captured in skid, in_ready = 0 and 0x08 is held by IF.
  - Then out_ready = 1 gives out_pc 0x00, 0x04, 0x08 in order with no loss.
- Flush with full buffer:
  - Stimulus: main 0x10 and skid 0x14 held; flush = 1 while IF offers 0x18.
  - Required: next cycle out_valid 0, in_ready 1; 0x18 is not delivered.
  - Next beat 0x80 delivered normally.
  - With IF_PERF_CNT_EN: drop_cnt += 2. 0x18 is not counted because in_ready = 0 in that cycle.
- Async reset mid-stall:
  - Stimulus: both entries full; rst = 0 between clock edges.
  - Required: out_valid drops to 0 before the next edge; after release, in_ready 1.
- Perf counters (IF_PERF_CNT_EN only):
  - Stimulus: in_valid = 1, out_ready = 0 for 10 cycles from empty.
  - Required: stall_cnt = 8; the first two beats are accepted and the next 8 cycles stall.

Source files
------------

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with valid/ready handshake, two-entry skid buffer and flush.
// Optional performance counters (stall_cnt, drop_cnt) are enabled by defining IF_PERF_CNT_EN.
module if_id_skid_reg #(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        drop_cnt
`endif
);

  logic               m_valid;
  logic [PC_W-1:0]    m_pc;
  logic [INSTR_W-1:0] m_instr;
  logic               s_valid;
  logic [PC_W-1:0]    s_pc;
  logic [INSTR_W-1:0] s_instr;
  logic               acc;
  logic               deq;

  assign acc       = in_valid & in_ready;
  assign deq       = m_valid & out_ready;
  assign in_ready  = ~s_valid;
  assign out_valid = m_valid;
  assign out_pc    = m_pc;
  assign out_instr = m_instr;

  // The skid entry only fills while main is stalled, so in_ready never depends on out_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid <= 1'b0;
      m_pc    <= RESET_PC;
      m_instr <= '0;
      s_valid <= 1'b0;
      s_pc    <= RESET_PC;
      s_instr <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid) begin
      if (acc) begin
        m_valid <= 1'b1;
        m_pc    <= in_pc;
        m_instr <= in_instr;
      end
    end else if (deq) begin
      if (s_valid) begin
        m_pc    <= s_pc;
        m_instr <= s_instr;
        s_valid <= 1'b0;
      end else if (acc) begin
        m_pc    <= in_pc;
        m_instr <= in_instr;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (acc) begin
      s_valid <= 1'b1;
      s_pc    <= in_pc;
      s_instr <= in_instr;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [1:0]  drop_inc;
  logic [32:0] drop_sum;

  // A main beat taken by ID in the flush cycle was delivered, so it is not a drop.
  assign drop_inc = {1'b0, m_valid & ~out_ready} + {1'b0, s_valid} + {1'b0, acc};
  assign drop_sum = {1'b0, drop_cnt} + {31'b0, drop_inc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (in_valid && !in_ready && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (flush)
        drop_cnt <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
    end
  end
`endif

endmodule
